// File: rtl/fifo_credit_param.sv
// rtl/fifo_credit_param.sv - credit-based router input buffer, DEPTH slots, one-hot pointers
// Optional post-reset credit initialisation sequence: FIFO_CREDIT_INIT_EN
module fifo_credit_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        RX,
    input  logic                         valid_in,
    input  logic                         read_en_N,
    input  logic                         read_en_E,
    input  logic                         read_en_W,
    input  logic                         read_en_S,
    input  logic                         read_en_L,
    output logic                         credit_out,
    output logic                         empty_out,
    output logic [DATA_WIDTH-1:0]        Data_out,
    output logic [$clog2(DEPTH+1)-1:0]   count_out,
    output logic                         overflow_err
);

    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      wr_ptr;
    logic [DEPTH-1:0]      rd_ptr;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  read_req;
    logic                  write_en;
    logic                  read_en;
    logic                  init_busy;
    logic                  credit_q;
    logic                  ovf_q;

    // Full/empty come from the occupancy counter; pointer equality is ambiguous.
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign read_req = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
    assign write_en = valid_in & ~full;
    assign read_en  = read_req & ~empty & ~init_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= DEPTH'(1);
            rd_ptr <= DEPTH'(1);
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (write_en)
                wr_ptr <= {wr_ptr[DEPTH-2:0], wr_ptr[DEPTH-1]};
            if (read_en)
                rd_ptr <= {rd_ptr[DEPTH-2:0], rd_ptr[DEPTH-1]};
            if (write_en && !read_en)
                count <= count + CW'(1);
            else if (read_en && !write_en)
                count <= count - CW'(1);
            if (valid_in && full)
                ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (write_en && wr_ptr[i])
                    mem[i] <= RX;
        end
    end

    // One-hot read pointer selects exactly one slot, so an OR-reduction is the mux.
    always_comb begin
        Data_out = '0;
        for (int i = 0; i < DEPTH; i++)
            if (rd_ptr[i])
                Data_out = Data_out | mem[i];
    end

`ifdef FIFO_CREDIT_INIT_EN
    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        state;
    logic [CW-1:0] init_cnt;

    // Hands DEPTH credits upstream after reset; reads are held off meanwhile.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_INIT;
            init_cnt <= DEPTH_C;
            credit_q <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    credit_q <= 1'b1;
                    init_cnt <= init_cnt - CW'(1);
                    if (init_cnt == CW'(1))
                        state <= S_RUN;
                end
                S_RUN: begin
                    credit_q <= read_en;
                end
                default: begin
                    state    <= S_RUN;
                    credit_q <= 1'b0;
                end
            endcase
        end
    end

    assign init_busy = (init_cnt != '0);
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            credit_q <= 1'b0;
        else
            credit_q <= read_en;
    end

    assign init_busy = 1'b0;
`endif

    assign credit_out   = credit_q;
    assign empty_out    = empty | init_busy;
    assign count_out    = count;
    assign overflow_err = ovf_q;

endmodule

// File: doc/fifo_credit_param.md
# fifo_credit_param

Parametrised credit-based input buffer for a router input port. It stores flits from the upstream link in a circular buffer of DEPTH entries with one-hot pointers, and presents the head flit combinationally to the five output-direction readers. It returns one credit pulse upstream per flit consumed. Unlike the fixed 4-slot version, all DEPTH slots are usable, occupancy and overflow are exposed, and a post-reset credit initialisation sequence can be compiled in.

## Interface
- DATA_WIDTH, 32, flit width in bits
- DEPTH, 4, number of buffer entries; integer >= 2; any value allowed, not restricted to powers of two
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- RX  input  DATA_WIDTH  incoming flit
- valid_in  input  1  RX holds a flit this cycle
- read_en_N, read_en_E, read_en_W, read_en_S, read_en_L  input  1 each  head-flit consume requests from the five allocators
- credit_out  output  1  registered one-cycle credit pulse to upstream
- empty_out  output  1  buffer holds no flit
- Data_out  output  DATA_WIDTH  head flit (first-word fall-through)
- count_out  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- overflow_err  output  1  sticky; set when a flit arrives while the buffer is full

## Operation
- Storage: DEPTH registers of DATA_WIDTH. Write and read pointers are DEPTH-bit one-hot vectors. Both reset to bit 0 and rotate left by one position per advance, wrapping from bit DEPTH-1 to bit 0.
- Occupancy: count register, reset 0. Full when count == DEPTH; empty when count == 0. Pointer equality is not used to decide full or empty.
- Write enable: write_en = valid_in & ~full. On write_en, the slot selected by the write pointer loads RX and the write pointer rotates. Other slots hold.
- Read enable: read_en = (OR of all five read_en_*) & ~empty & ~init_busy. On read_en, the read pointer rotates. Slot contents are not cleared.
- Count update: +1 on write only, -1 on read only, unchanged when both or neither occur.
- Data_out: mux of the slot selected by the read pointer. When empty, Data_out shows stale data and carries no meaning.
- Overflow: valid_in & full sets overflow_err. The flit is dropped and no state changes. overflow_err clears only on reset.
- Multiple read_en_* asserted together count as a single read.
- Reset values: both pointers = 1, all slots = 0, count_out = 0, empty_out = 1, credit_out = 0, overflow_err = 0, Data_out = 0.
- Reset asserted mid-operation: all state returns to reset values immediately and asynchronously. Buffered flits and pending credits are lost.

## Timing
- Write-to-visible latency: a flit written at edge k appears on Data_out, with empty_out low, after edge k.
- Read: consumption takes effect at the edge where read_en is high. The next flit appears after that edge.
- credit_out is high for exactly the one cycle following each read edge. Back-to-back reads produce a continuous high level, one credit per cycle.
- Simultaneous read and write when full: the read proceeds. The write is blocked because full is evaluated before the edge, and overflow_err sets. Upstream credit accounting makes this a protocol violation.
- Simultaneous read and write when 0 < count < DEPTH: both proceed and count is unchanged.
- Write when empty with a read request in the same cycle: only the write occurs.
- Pointer wrap: after DEPTH advances, a pointer returns to bit 0.

## Configuration
- Macro FIFO_CREDIT_INIT_EN.
- Defined:
  - After reset deassertion, an INIT state drives credit_out high for exactly DEPTH consecutive cycles, starting on the first rising edge after reset release. Upstream resets its credit counter to 0.
  - A down-counter (reset DEPTH) tracks INIT. init_busy is high while the counter is nonzero, then the block moves to RUN.
  - During INIT, read_en is forced to 0 and empty_out is forced to 1. Writes are still accepted.
- Not defined:
  - No INIT state; init_busy is constant 0.
  - Upstream resets its credit counter to DEPTH.
  - credit_out stays 0 after reset until the first read.

## Test plan
- Fill and drain, DEPTH=4, DATA_WIDTH=32: write 0xA0..0xA3 on 4 consecutive cycles -> count_out=4 and empty_out=0. Then assert read_en_L for 4 cycles -> Data_out steps through 0xA0,0xA1,0xA2,0xA3, credit_out is high for 4 cycles each lagging its read by 1, and finally count_out=0, empty_out=1.
- Wrap-around, DEPTH=5: 12 writes interleaved with reads, occupancy kept between 1 and 4 -> output order equals input order and both pointers return to bit 0 after 10 advances.
- Simultaneous read and write at count=2 -> count stays 2, one credit pulse, head flit advances.
- Overflow: fill to DEPTH, then drive valid_in with RX=0xDEAD -> overflow_err=1, count_out=DEPTH, 0xDEAD is never output, and overflow_err stays 1 until reset.
- Multi-reader: read_en_N and read_en_E high together for one cycle at count=3 -> count becomes 2 and exactly one credit pulse is produced.
- Reset mid-operation: at count=3, pulse reset low -> all outputs return to reset values asynchronously. With FIFO_CREDIT_INIT_EN defined, exactly DEPTH credit pulses follow release; a read_en_S during INIT is ignored.
